// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a 32-bit word memory, with misaligned
// accesses split into two consecutive word transactions.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [31:0]           Address,
    input  logic [31:0]           DataWr,
    input  logic                  DMWr,
    input  logic [2:0]            DMCtrl,
    output logic                  RspValid,
    output logic [31:0]           DataRd,
    output logic                  RspErr,
    output logic                  MemReq,
    input  logic                  MemAck,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemWe,
    output logic [3:0]            MemBe,
    output logic [31:0]           MemWData,
    input  logic [31:0]           MemRData
);

    localparam int unsigned BA_W = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                r_state, w_state_nxt;
    logic [BA_W-1:0]       r_addr;
    logic [31:0]           r_wdata;
    logic                  r_wr;
    logic [2:0]            r_ctrl;
    logic [31:0]           r_lo, r_hi;

    logic                  w_mem_req, w_mem_we, w_rsp_valid, w_rsp_err;
    logic [3:0]            w_mem_be;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [31:0]           w_mem_wdata, w_data_rd;

    logic [BA_W-1:0]       w_addr;
    logic [31:0]           w_wdata;
    logic                  w_wr;
    logic [2:0]            w_ctrl;
    logic [2:0]            w_size;
    logic                  w_legal, w_mis, w_sgn;
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_word, w_word_next;
    logic [7:0]            w_be_span;
    logic [63:0]           w_wd_span;
    logic [31:0]           w_lo, w_hi, w_rd_cat, w_load;
    logic                  w_unused;

    assign w_unused = ^Address[31:BA_W];

    assign ReqReady = (r_state == IDLE) && !rst;

    // In IDLE the live request is decoded so the first memory beat can be registered at accept
    assign w_addr  = (r_state == IDLE) ? Address[BA_W-1:0] : r_addr;
    assign w_wdata = (r_state == IDLE) ? DataWr : r_wdata;
    assign w_wr    = (r_state == IDLE) ? DMWr : r_wr;
    assign w_ctrl  = (r_state == IDLE) ? DMCtrl : r_ctrl;

    always_comb begin
        w_size = 3'd4;
        case (w_ctrl)
            3'b000, 3'b100, 3'b110: w_size = 3'd1;
            3'b001, 3'b101, 3'b111: w_size = 3'd2;
            default:                w_size = 3'd4;
        endcase
    end

    assign w_legal     = w_wr ? (w_ctrl inside {3'b110, 3'b111, 3'b011})
                              : (w_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_off       = w_addr[1:0];
    assign w_word      = w_addr[BA_W-1:2];
    assign w_word_next = w_word + ADDR_WIDTH'(1);
    assign w_mis       = ({1'b0, w_off} + w_size) > 3'd4;

    // Low nibble = first-beat lanes, high nibble = second-beat lanes
    assign w_be_span = 8'((8'd1 << w_size) - 8'd1) << w_off;
    assign w_wd_span = {32'd0, w_wdata} << {w_off, 3'b000};

    assign w_lo     = (r_state == ACC0 && MemAck) ? MemRData : r_lo;
    assign w_hi     = (r_state == ACC1 && MemAck) ? MemRData : r_hi;
    assign w_rd_cat = 32'({w_hi, w_lo} >> {w_off, 3'b000});
    assign w_sgn    = ~w_ctrl[2];

    always_comb begin
        w_load = w_rd_cat;
        case (w_size)
            3'd1:    w_load = {{24{w_sgn & w_rd_cat[7]}}, w_rd_cat[7:0]};
            3'd2:    w_load = {{16{w_sgn & w_rd_cat[15]}}, w_rd_cat[15:0]};
            default: w_load = w_rd_cat;
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_be    = 4'd0;
        w_mem_addr  = MemAddr;
        w_mem_wdata = MemWData;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_data_rd   = 32'd0;
        case (r_state)
            IDLE: begin
                if (ReqValid) begin
                    if (!w_legal) begin
                        w_state_nxt = RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else begin
                        w_state_nxt = ACC0;
                        w_mem_req   = 1'b1;
                        w_mem_we    = w_wr;
                        w_mem_be    = w_be_span[3:0];
                        w_mem_addr  = w_word;
                        w_mem_wdata = w_wd_span[31:0];
                    end
                end
            end
            ACC0: begin
                w_mem_req = 1'b1;
                w_mem_we  = MemWe;
                w_mem_be  = MemBe;
                if (MemAck) begin
                    if (w_mis) begin
                        w_state_nxt = ACC1;
                        w_mem_be    = w_be_span[7:4];
                        w_mem_addr  = w_word_next;
                        w_mem_wdata = w_wd_span[63:32];
                    end else begin
                        w_state_nxt = RESP;
                        w_mem_req   = 1'b0;
                        w_mem_we    = 1'b0;
                        w_mem_be    = 4'd0;
                        w_rsp_valid = 1'b1;
                        w_data_rd   = w_wr ? 32'd0 : w_load;
                    end
                end
            end
            ACC1: begin
                w_mem_req = 1'b1;
                w_mem_we  = MemWe;
                w_mem_be  = MemBe;
                if (MemAck) begin
                    w_state_nxt = RESP;
                    w_mem_req   = 1'b0;
                    w_mem_we    = 1'b0;
                    w_mem_be    = 4'd0;
                    w_rsp_valid = 1'b1;
                    w_data_rd   = w_wr ? 32'd0 : w_load;
                end
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_wr     <= 1'b0;
            r_ctrl   <= 3'd0;
            r_lo     <= 32'd0;
            r_hi     <= 32'd0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemBe    <= 4'd0;
            MemAddr  <= '0;
            MemWData <= 32'd0;
            RspValid <= 1'b0;
            RspErr   <= 1'b0;
            DataRd   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && ReqValid) begin
                r_addr  <= Address[BA_W-1:0];
                r_wdata <= DataWr;
                r_wr    <= DMWr;
                r_ctrl  <= DMCtrl;
            end
            r_lo     <= w_lo;
            r_hi     <= w_hi;
            MemReq   <= w_mem_req;
            MemWe    <= w_mem_we;
            MemBe    <= w_mem_be;
            MemAddr  <= w_mem_addr;
            MemWData <= w_mem_wdata;
            RspValid <= w_rsp_valid;
            RspErr   <= w_rsp_err;
            DataRd   <= w_data_rd;
        end
    end

endmodule
